pic_inta_master: RTL and testbench



---
 rtl/pic_inta_master.sv | 128 ++++++++++++
 tb/tb_pic_inta_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_inta_master.sv
// Processor-side 8259 interrupt acknowledge initiator: runs the two-pulse INTA
// sequence, captures the vector and issues the OCW2 EOI write when needed.
module pic_inta_master #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1,
    parameter int WR_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_req,
    input  logic [7:0] data_in,
    input  logic       aeoi_mode,
    input  logic       specific_eoi,
    input  logic [2:0] specific_level,
    input  logic       handler_done,
    output logic       inta_n,
    output logic       cs_n,
    output logic       wr_n,
    output logic       a0,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE, INTA1, GAP1, INTA2, VEC, WAIT_DONE, EOI_WR, EOI_GAP
    } state_t;

    localparam logic [7:0] PULSE_M1 = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_M1   = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] WR_M1    = 8'(WR_CYCLES - 1);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       sync1, int_s;
    logic       aeoi_l;

    // OCW2 writes always target the A0 = 0 register, so the address is fixed.
    assign a0        = 1'b0;
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        cnt_next   = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
        case (state)
            IDLE: begin
                if (int_s) begin
                    state_next = INTA1;
                    cnt_next   = PULSE_M1;
                end
            end
            INTA1: begin
                if (cnt == 8'd0) begin
                    state_next = GAP1;
                    cnt_next   = GAP_M1;
                end
            end
            GAP1: begin
                if (cnt == 8'd0) begin
                    state_next = INTA2;
                    cnt_next   = PULSE_M1;
                end
            end
            INTA2: begin
                if (cnt == 8'd0) state_next = VEC;
            end
            VEC: state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (handler_done) begin
                    state_next = aeoi_l ? IDLE : EOI_WR;
                    cnt_next   = WR_M1;
                end
            end
            EOI_WR: begin
                if (cnt == 8'd0) begin
                    state_next = EOI_GAP;
                    cnt_next   = GAP_M1;
                end
            end
            EOI_GAP: begin
                if (cnt == 8'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            sync1        <= 1'b0;
            int_s        <= 1'b0;
            aeoi_l       <= 1'b0;
            inta_n       <= 1'b1;
            cs_n         <= 1'b1;
            wr_n         <= 1'b1;
            data_out     <= 8'h00;
            data_oe      <= 1'b0;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sync1        <= int_req;
            int_s        <= sync1;
            state        <= state_next;
            cnt          <= cnt_next;
            inta_n       <= !(state_next == INTA1 || state_next == INTA2);
            cs_n         <= !(state_next == EOI_WR);
            wr_n         <= !(state_next == EOI_WR);
            // Bus drive outlasts the write strobe by one clock of hold time.
            data_oe      <= (state_next == EOI_WR) ||
                            (state == EOI_WR && state_next == EOI_GAP);
            vector_valid <= (state_next == VEC);
            busy         <= (state_next != IDLE);
            if (state == IDLE && int_s)
                aeoi_l <= aeoi_mode;
            if (state == INTA2 && cnt == 8'd0)
                vector <= data_in;
            if (state == WAIT_DONE && handler_done && !aeoi_l)
                data_out <= specific_eoi ? {5'b01100, specific_level} : 8'h20;
        end
    end

endmodule

// File: tb/tb_pic_inta_master.sv
// Directed bench for pic_inta_master: INTA timing, vector capture, EOI writes,
// AEOI suppression, back-to-back service and asynchronous reset.
module tb_pic_inta_master;

    localparam int PULSE = 2;
    localparam int GAP   = 1;
    localparam int WR    = 2;

    logic       clk;
    logic       rst_n;
    logic       int_req;
    logic [7:0] data_in;
    logic       aeoi_mode;
    logic       specific_eoi;
    logic [2:0] specific_level;
    logic       handler_done;
    logic       inta_n, cs_n, wr_n, a0;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] vector;
    logic       vector_valid;
    logic       busy;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;

    logic [7:0] vec_q[$];
    logic [7:0] eoi_q[$];

    pic_inta_master #(
        .PULSE_CYCLES(PULSE),
        .GAP_CYCLES  (GAP),
        .WR_CYCLES   (WR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .int_req       (int_req),
        .data_in       (data_in),
        .aeoi_mode     (aeoi_mode),
        .specific_eoi  (specific_eoi),
        .specific_level(specific_level),
        .handler_done  (handler_done),
        .inta_n        (inta_n),
        .cs_n          (cs_n),
        .wr_n          (wr_n),
        .a0            (a0),
        .data_out      (data_out),
        .data_oe       (data_oe),
        .vector        (vector),
        .vector_valid  (vector_valid),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: vector pulses
    logic prev_vv = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vv = 1'b0;
        end else begin
            if (vector_valid) begin
                if (prev_vv) check("vector_valid_width", 8'd2, 8'd1);
                if (vec_q.size() == 0) check("unexpected_vector", vector, 8'hxx);
                else check("vector", vector, vec_q.pop_front());
            end
            prev_vv = vector_valid;
        end
    end

    // monitor: EOI write transactions
    logic       prev_wr = 1'b1;
    int         wr_run  = 0;
    logic [7:0] wr_byte = 8'h00;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wr = 1'b1;
            wr_run  = 0;
        end else begin
            if (!wr_n && prev_wr) begin
                wr_run  = 0;
                wr_byte = data_out;
                if (eoi_q.size() == 0) check("unexpected_eoi", data_out, 8'hxx);
                else check("eoi_byte", data_out, eoi_q.pop_front());
                check("eoi_cs_n", cs_n, 8'd0);
                check("eoi_a0", a0, 8'd0);
                check("eoi_oe", data_oe, 8'd1);
            end
            if (!wr_n) wr_run++;
            if (wr_n && !prev_wr) begin
                check("eoi_wr_width", 8'(wr_run), 8'(WR));
                check("eoi_hold_oe", data_oe, 8'd1);
                check("eoi_hold_data", data_out, wr_byte);
            end
            prev_wr = wr_n;
        end
    end

    // driver tasks; k counts edges after int_req is first sampled high
    task automatic seq_body(input int first_k, input bit keep, input bit hd_vec);
        logic [7:0] inta_hi;
        inta_hi = 8'b1001_0010;
        for (int k = first_k; k <= 7; k++) begin
            tick();
            check($sformatf("inta_n_k%0d", k), inta_n, 8'(inta_hi[k]));
            if (k == 7) check("vector_valid_k7", vector_valid, 8'd1);
            if (k == 2 && !keep) int_req = 1'b0;
            if (k == 3) aeoi_mode = 1'b0;
        end
        if (hd_vec) handler_done = 1'b1;
        tick();
        handler_done = 1'b0;
        check("vector_valid_k8", vector_valid, 8'd0);
        check("busy_k8", busy, 8'd1);
        check("wr_n_k8", wr_n, 8'd1);
    endtask

    task automatic start_seq(input logic [7:0] d, input bit aeoi, input bit keep, input bit hd_vec);
        data_in   = d;
        aeoi_mode = aeoi;
        int_req   = 1'b1;
        vec_q.push_back(d);
        tick();
        seq_body(1, keep, hd_vec);
    endtask

    task automatic finish_eoi(input bit spec, input logic [2:0] lvl, input logic [7:0] exp_byte);
        specific_eoi   = spec;
        specific_level = lvl;
        handler_done   = 1'b1;
        eoi_q.push_back(exp_byte);
        tick();
        handler_done = 1'b0;
        check("eoi_wr_n_h0", wr_n, 8'd0);
        check("eoi_data_h0", data_out, exp_byte);
        tick();
        check("eoi_wr_n_h1", wr_n, 8'd0);
        tick();
        check("eoi_wr_n_h2", wr_n, 8'd1);
        check("eoi_busy_h2", busy, 8'd1);
        tick();
        check("eoi_busy_h3", busy, 8'd0);
        check("eoi_oe_h3", data_oe, 8'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        int_req        = 1'b0;
        data_in        = 8'h00;
        aeoi_mode      = 1'b0;
        specific_eoi   = 1'b0;
        specific_level = 3'd0;
        handler_done   = 1'b0;
        repeat (3) tick();
        check("rst_inta_n", inta_n, 8'd1);
        check("rst_cs_n", cs_n, 8'd1);
        check("rst_wr_n", wr_n, 8'd1);
        check("rst_a0", a0, 8'd0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_oe", data_oe, 8'd0);
        check("rst_vector", vector, 8'h00);
        check("rst_vector_valid", vector_valid, 8'd0);
        check("rst_busy", busy, 8'd0);
        rst_n = 1'b1;
        tick();

        // handler_done in IDLE does nothing
        handler_done = 1'b1;
        tick();
        handler_done = 1'b0;
        check("idle_hd_busy", busy, 8'd0);
        check("idle_hd_wr_n", wr_n, 8'd1);

        // basic service, non-specific EOI; handler_done during VEC ignored
        start_seq(8'h4B, 1'b0, 1'b0, 1'b1);
        finish_eoi(1'b0, 3'd0, 8'h20);
        tick();

        // specific EOI, level 5
        start_seq(8'h8A, 1'b0, 1'b0, 1'b0);
        finish_eoi(1'b1, 3'd5, 8'h65);
        tick();

        // AEOI latched at start, input toggled low mid-sequence
        start_seq(8'h33, 1'b1, 1'b0, 1'b0);
        handler_done = 1'b1;
        tick();
        handler_done = 1'b0;
        check("aeoi_busy", busy, 8'd0);
        check("aeoi_wr_n", wr_n, 8'd1);
        tick();
        check("aeoi_wr_n_after", wr_n, 8'd1);
        tick();

        // back-to-back service with int_req held high
        start_seq(8'h51, 1'b0, 1'b1, 1'b0);
        finish_eoi(1'b0, 3'd0, 8'h20);
        tick();
        check("b2b_inta_n", inta_n, 8'd0);
        check("b2b_busy", busy, 8'd1);
        int_req = 1'b0;
        data_in = 8'h52;
        vec_q.push_back(8'h52);
        seq_body(3, 1'b0, 1'b0);
        finish_eoi(1'b1, 3'd3, 8'h63);
        tick();

        // asynchronous reset during INTA2
        data_in = 8'hC7;
        int_req = 1'b1;
        tick();
        repeat (5) tick();
        check("pre_rst_inta_n", inta_n, 8'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_inta_n", inta_n, 8'd1);
        check("mid_rst_busy", busy, 8'd0);
        check("mid_rst_vector", vector, 8'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        vec_q.push_back(8'hC7);
        tick();
        seq_body(1, 1'b0, 1'b0);
        finish_eoi(1'b0, 3'd0, 8'h20);

        repeat (3) tick();
        check("vec_q_empty", 8'(vec_q.size()), 8'd0);
        check("eoi_q_empty", 8'(eoi_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
